// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-read-port register file.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN (write-first forwarding).
package regfile_pkg;

  // Sweep controller states: CLEAR zeroes the array, RUN serves the datapath.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_RD_PORTS = 2;
  localparam int DEF_ZERO_REG = 1;

  // Lowest bit of field idx inside a flat bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: clear-sweep controller. Walks ptr across every entry
// after reset or on clear_req, gates user writes until the sweep is done and
// reports writes that were discarded.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_req_i,
  input  logic              we_i,
  input  logic              wr_zero_i,    // write targets the hard-wired zero entry
  output logic              ready_o,
  output logic              wr_drop_o,
  output logic              wr_commit_o,  // user write lands in the array this edge
  output logic              clr_we_o,     // sweep write strobe
  output logic [ADDR_W-1:0] clr_addr_o    // sweep write address
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              ready_q;
  logic              wr_drop_q;
  logic              wr_commit_d;

  // Incremented sweep pointer and the user-write commit decision.
  always_comb begin
    ptr_d       = ptr_q + 1'b1;
    wr_commit_d = we_i && ready_q && !wr_zero_i;
  end

  // State, pointer and registered outputs; ready_q mirrors (state == RUN).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= we_i && !wr_commit_d;
      case (state_q)
        ST_CLEAR: begin
          // clear_req is ignored here: the sweep already zeroes everything.
          if (ptr_q == PTR_LAST) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_d;
          end
        end
        ST_RUN: begin
          // A write in the same cycle still commits; the sweep overwrites it.
          if (clear_req_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign wr_drop_o   = wr_drop_q;
  assign wr_commit_o = wr_commit_d;
  assign clr_we_o    = (state_q == ST_CLEAR);
  assign clr_addr_o  = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: general-purpose register bank with one clocked write port and
// RD_PORTS combinational read ports. Entry 0 optionally reads as zero.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding from
// wdata_i to any read port addressing the entry being written this cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [RD_PORTS*ADDR_W-1:0] raddr_i,
  output logic [RD_PORTS*DATA_W-1:0] rdata_o,
  input  logic                       clear_req_i,
  output logic                       ready_o,
  output logic                       wr_drop_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is deliberately unreset; the sweep establishes known contents.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_zero;
  logic              wr_commit;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_d;

  assign wr_zero = (ZERO_REG != 0) && (waddr_i == '0);

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_req_i (clear_req_i),
    .we_i        (we_i),
    .wr_zero_i   (wr_zero),
    .ready_o     (ready),
    .wr_drop_o   (wr_drop_o),
    .wr_commit_o (wr_commit),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // Write port mux: sweep and user writes never coincide (commit needs ready).
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = waddr_i;
    mem_data_d = wdata_i;
    if (clr_we) begin
      mem_we_d   = 1'b1;
      mem_addr_d = clr_addr;
      mem_data_d = '0;
    end else if (wr_commit) begin
      mem_we_d = 1'b1;
    end
  end

  // Array update.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[mem_addr_d] <= mem_data_d;
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    localparam int ALO = slice_lo(g, ADDR_W);
    localparam int DLO = slice_lo(g, DATA_W);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr_i[ALO +: ADDR_W];

    // Per-port read: array (or forwarded write data), then zero/ready masking.
    always_comb begin
      rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (ra == waddr_i)) begin
        rd = wdata_i;
      end
`endif
      if (!ready || ((ZERO_REG != 0) && (ra == '0))) begin
        rd = '0;
      end
    end

    assign rdata_o[DLO +: DATA_W] = rd;
  end

  assign ready_o = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp. Two instances
// share stimulus: one with the zero register, one with an ordinary entry 0.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NP*AW-1:0] raddr;
  logic          clear_req;
  logic [NP*DW-1:0] rdata_z, rdata_n;
  logic          ready_z, ready_n, drop_z, drop_n;

  int checks = 0;
  int errors = 0;

  // Reference model: entries left to sweep (0 means serving), contents, drop flags.
  int          sweep_left;
  logic [DW-1:0] mem_z [DEPTH];
  logic [DW-1:0] mem_n [DEPTH];
  logic        exp_drop_z, exp_drop_n;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(1)) u_dut_z (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_z), .clear_req_i(clear_req),
    .ready_o(ready_z), .wr_drop_o(drop_z));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(0)) u_dut_n (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_n), .clear_req_i(clear_req),
    .ready_o(ready_n), .wr_drop_o(drop_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input bit zr, input logic [AW-1:0] a);
    if (sweep_left != 0) return '0;
    if (zr && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !(zr && waddr == '0) && a == waddr) return wdata;
`endif
    return zr ? mem_z[a] : mem_n[a];
  endfunction

  // One clock edge; the model consumes the inputs the DUT sees at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (sweep_left > 0) begin
        mem_z[DEPTH - sweep_left] = '0;
        mem_n[DEPTH - sweep_left] = '0;
        sweep_left--;
        exp_drop_z = we;
        exp_drop_n = we;
      end else begin
        exp_drop_z = we && (waddr == '0);
        exp_drop_n = 1'b0;
        if (we && waddr != '0) mem_z[waddr] = wdata;
        if (we) mem_n[waddr] = wdata;
        if (clear_req) sweep_left = DEPTH;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; clear_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sweep_left = DEPTH; exp_drop_z = 1'b0; exp_drop_n = 1'b0;
    idle_inputs();
    raddr = 10'($urandom);
    #2;
    checks++;
    if (ready_z !== 1'b0 || drop_z !== 1'b0 || rdata_z !== '0 || rdata_n !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b drop=%b rdata_z=%h rdata_n=%h exp 0", ready_z, drop_z, rdata_z, rdata_n);
    end
    tick(); tick(); tick();
    rst = 1'b0;
    for (int n = 1; n <= DEPTH; n++) begin
      raddr = 10'($urandom);
      #1;
      checks++;
      if (rdata_z !== '0 || rdata_n !== '0) begin
        errors++;
        $display("FAIL reset_sweep_rdata edge %0d got %h/%h exp 0", n, rdata_z, rdata_n);
      end
      tick();
      checks++;
      if (ready_z !== (n == DEPTH) || ready_n !== (n == DEPTH)) begin
        errors++;
        $display("FAIL reset_ready edge %0d got %b/%b exp %b", n, ready_z, ready_n, (n == DEPTH));
      end
    end
    for (int k = 0; k < 8; k++) begin
      raddr = 10'($urandom);
      #1;
      checks++;
      if (rdata_z !== '0 || rdata_n !== '0) begin
        errors++;
        $display("FAIL reset_after_rdata got %h/%h exp 0", rdata_z, rdata_n);
      end
      tick();
    end
  endtask

  task automatic test_basic_write();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    raddr = {5'd5, 5'd5};
    #1;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rdata_z[p*DW +: DW] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL basic_read port %0d got %h exp deadbeef", p, rdata_z[p*DW +: DW]);
      end
    end
    checks++;
    if (drop_z !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_drop got %b exp 0", drop_z);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    tick();
    we = 1'b0;
    raddr = {5'd0, 5'd0};
    checks++;
    if (drop_z !== 1'b1 || drop_n !== 1'b0) begin
      errors++;
      $display("FAIL zero_drop got z=%b n=%b exp z=1 n=0", drop_z, drop_n);
    end
    #1;
    checks++;
    if (rdata_z !== '0) begin
      errors++;
      $display("FAIL zero_read_z got %h exp 0", rdata_z);
    end
    checks++;
    if (rdata_n[DW-1:0] !== 32'h1234 || rdata_n[2*DW-1:DW] !== 32'h1234) begin
      errors++;
      $display("FAIL zero_read_n got %h exp 1234 on both ports", rdata_n);
    end
    tick();
    checks++;
    if (drop_z !== 1'b0) begin
      errors++;
      $display("FAIL zero_drop_width got %b exp 0", drop_z);
    end
  endtask

  task automatic test_sweep_drop();
    int k;
    logic [DW-1:0] v;
    v = $urandom;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (ready_z !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready_low got %b exp 0", ready_z);
    end
    we = 1'b1; waddr = 5'd7; wdata = v;
    tick();
    we = 1'b0;
    checks++;
    if (drop_z !== 1'b1 || drop_n !== 1'b1) begin
      errors++;
      $display("FAIL sweep_drop got %b/%b exp 1", drop_z, drop_n);
    end
    for (k = 3; k <= 40; k++) begin
      tick();
      if (ready_z) break;
    end
    checks++;
    if (k != DEPTH + 1) begin
      errors++;
      $display("FAIL clear_to_ready edges got %0d exp %0d", k, DEPTH + 1);
    end
    raddr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rdata_z !== '0 || rdata_n !== '0) begin
      errors++;
      $display("FAIL sweep_r7 got %h/%h exp 0", rdata_z, rdata_n);
    end
    clear_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    tick();
    clear_req = 1'b0; we = 1'b0;
    checks++;
    if (ready_z !== 1'b0 || drop_z !== 1'b0) begin
      errors++;
      $display("FAIL clear_with_write ready=%b drop=%b exp 0 0", ready_z, drop_z);
    end
    for (k = 2; k <= 40; k++) begin
      tick();
      if (ready_z) break;
    end
    checks++;
    if (k != DEPTH + 1) begin
      errors++;
      $display("FAIL reclear_to_ready edges got %0d exp %0d", k, DEPTH + 1);
    end
    raddr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rdata_z !== '0 || rdata_n !== '0) begin
      errors++;
      $display("FAIL resweep_r3 got %h/%h exp 0", rdata_z, rdata_n);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd9; wdata = 32'h77;
    tick();
    wdata = 32'h55;
    raddr = {5'd1, 5'd9};
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rdata_z[DW-1:0] !== 32'h55) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h exp 55", rdata_z[DW-1:0]);
    end
`else
    if (rdata_z[DW-1:0] !== 32'h77) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h exp 77", rdata_z[DW-1:0]);
    end
`endif
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata_z[DW-1:0] !== 32'h55) begin
      errors++;
      $display("FAIL bypass_after_edge got %h exp 55", rdata_z[DW-1:0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we = ($urandom_range(0, 2) != 0);
      waddr = 5'($urandom);
      wdata = $urandom;
      raddr = 10'($urandom);
      clear_req = ($urandom_range(0, 59) == 0);
      #1;
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (rdata_z[p*DW +: DW] !== exp_rd(1'b1, raddr[p*AW +: AW])) begin
          errors++;
          $display("FAIL rand_rdata_z cyc %0d port %0d got %h exp %h", c, p, rdata_z[p*DW +: DW], exp_rd(1'b1, raddr[p*AW +: AW]));
        end
        checks++;
        if (rdata_n[p*DW +: DW] !== exp_rd(1'b0, raddr[p*AW +: AW])) begin
          errors++;
          $display("FAIL rand_rdata_n cyc %0d port %0d got %h exp %h", c, p, rdata_n[p*DW +: DW], exp_rd(1'b0, raddr[p*AW +: AW]));
        end
      end
      checks++;
      if (ready_z !== (sweep_left == 0) || drop_z !== exp_drop_z || drop_n !== exp_drop_n) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d ready=%b drop=%b/%b exp %b %b/%b", c, ready_z, drop_z, drop_n, (sweep_left == 0), exp_drop_z, exp_drop_n);
      end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 40 && sweep_left != 0; k++) tick();
  endtask

  task automatic test_reset_mid_sweep();
    int k;
    we = 1'b1; waddr = 5'd11; wdata = 32'hCAFE0011;
    tick();
    we = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    #2;
    rst = 1'b1; sweep_left = DEPTH; exp_drop_z = 1'b0; exp_drop_n = 1'b0;
    #1;
    checks++;
    if (ready_z !== 1'b0 || drop_z !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state ready=%b drop=%b exp 0 0", ready_z, drop_z);
    end
    tick(); tick();
    rst = 1'b0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (ready_z) break;
    end
    checks++;
    if (k != DEPTH) begin
      errors++;
      $display("FAIL midreset_ready edges got %0d exp %0d", k, DEPTH);
    end
    raddr = {5'd11, 5'd11};
    #1;
    checks++;
    if (rdata_z !== '0 || rdata_n !== '0) begin
      errors++;
      $display("FAIL midreset_r11 got %h/%h exp 0", rdata_z, rdata_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_sweep_drop();
    test_bypass();
    test_random();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
